// File: rtl/pacman_map_pkg.sv
// Shared definitions for the map-RAM sprite writer: tile codes, the writer
// state encoding and the row-word column addressing helper.
package pacman_map_pkg;

    localparam int TILE_EMPTY  = 0;
    localparam int TILE_WALL   = 1;
    localparam int TILE_PILL   = 2;
    localparam int TILE_PACMAN = 3;
    localparam int TILE_GHOST  = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_E   = 4'd1,
        ST_WAIT_E = 4'd2,
        ST_WR_E   = 4'd3,
        ST_RD_D   = 4'd4,
        ST_WAIT_D = 4'd5,
        ST_WR_D   = 4'd6,
        ST_DONE   = 4'd7
    } wr_state_t;

    // LSB offset of column c inside a row word; column 0 sits at the MSB end.
    function automatic int col_slice(input int c, input int cols, input int tile_w);
        return (cols - 1 - c) * tile_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr,
// wrapping around. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          grant_valid,
    output logic [PW-1:0] grant_idx
);

    // Index reached by stepping off positions forward from base, modulo N.
    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N) ? (s - N) : s;
    endfunction

    // Scan from ptr upward; the first requester found keeps the grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_valid && req[wrap_idx(int'(ptr), k)]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(wrap_idx(int'(ptr), k));
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/sprite_map_writer.sv
// Read-modify-write engine on map RAM port B. Each granted sprite request
// erases the sprite from its current cell (restoring the covered tile, or
// leaving an empty tile for eating sprites) and then draws it at its next cell,
// remembering the tile it now covers.
module sprite_map_writer
    import pacman_map_pkg::*;
#(
    parameter int                     NUM_SPRITES = 3,
    parameter int                     COLS        = 40,
    parameter int                     ROWS        = 30,
    parameter int                     TILE_W      = 4,
    parameter int                     RD_LATENCY  = 2,
    parameter logic [NUM_SPRITES-1:0] EATS_MASK   = 3'b001
) (
    input  logic                                   CLOCK_50,
    input  logic                                   reset,
    input  logic [NUM_SPRITES-1:0]                 req,
    input  logic [NUM_SPRITES*$clog2(COLS)-1:0]    curr_x,
    input  logic [NUM_SPRITES*$clog2(ROWS)-1:0]    curr_y,
    input  logic [NUM_SPRITES*$clog2(COLS)-1:0]    next_x,
    input  logic [NUM_SPRITES*$clog2(ROWS)-1:0]    next_y,
    input  logic [NUM_SPRITES*TILE_W-1:0]          sprite_tile,
    input  logic [COLS*TILE_W-1:0]                 redata,
    output logic [$clog2(ROWS)-1:0]                wraddr,
    output logic [COLS*TILE_W-1:0]                 wrdata,
    output logic                                   wren,
    output logic [NUM_SPRITES-1:0]                 done,
    output logic                                   err,
    output logic [TILE_W-1:0]                      hit_tile,
    output logic                                   busy
);

    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);
    localparam int ROW_W = COLS * TILE_W;
    localparam int PW    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CW    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [CW-1:0]     LAT_LAST  = CW'(RD_LATENCY - 1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1'b1);
    localparam logic [XW:0]       COLS_L    = COLS[XW:0];
    localparam logic [YW:0]       ROWS_L    = ROWS[YW:0];
    localparam logic [TILE_W-1:0] EMPTY_T   = TILE_W'(TILE_EMPTY);

    // Latched request context and control state.
    wr_state_t         state_r;
    logic [PW-1:0]     idx_r;
    logic [XW-1:0]     cx_r;
    logic [YW-1:0]     cy_r;
    logic [XW-1:0]     nx_r;
    logic [YW-1:0]     ny_r;
    logic [TILE_W-1:0] tile_r;
    logic [PW-1:0]     rr_ptr_r;
    logic [CW-1:0]     wait_cnt_r;
    logic [TILE_W-1:0] under_r [NUM_SPRITES];

    // Grant-side decode of the winning sprite's inputs.
    logic              grant_valid_s;
    logic [PW-1:0]     grant_idx_s;
    logic [XW-1:0]     gcx_s;
    logic [YW-1:0]     gcy_s;
    logic [XW-1:0]     gnx_s;
    logic [YW-1:0]     gny_s;
    logic [TILE_W-1:0] gtile_s;
    logic              range_ok_s;
    logic              same_cell_s;
    logic [TILE_W-1:0] erase_tile_s;
    logic [TILE_W-1:0] old_tile_s;

    // Tile at column c of a row word.
    function automatic logic [TILE_W-1:0] get_col(input logic [ROW_W-1:0] row,
                                                  input logic [XW-1:0]    c);
        return row[col_slice(int'(c), COLS, TILE_W) +: TILE_W];
    endfunction

    // Row word with column c replaced by tile t; other columns untouched.
    function automatic logic [ROW_W-1:0] put_col(input logic [ROW_W-1:0]  row,
                                                 input logic [XW-1:0]     c,
                                                 input logic [TILE_W-1:0] t);
        logic [ROW_W-1:0] r;
        r = row;
        r[col_slice(int'(c), COLS, TILE_W) +: TILE_W] = t;
        return r;
    endfunction

    // One-hot vector with bit i set.
    function automatic logic [NUM_SPRITES-1:0] onehot(input logic [PW-1:0] i);
        logic [NUM_SPRITES-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin pointer value following a grant to index i.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        if (int'(i) == NUM_SPRITES - 1) begin
            return '0;
        end else begin
            return i + PW'(1'b1);
        end
    endfunction

    rr_arbiter #(
        .N  (NUM_SPRITES),
        .PW (PW)
    ) u_arb (
        .req         (req),
        .ptr         (rr_ptr_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Select the granted sprite's coordinates and classify the request.
    always_comb begin
        gcx_s       = curr_x[int'(grant_idx_s)*XW +: XW];
        gcy_s       = curr_y[int'(grant_idx_s)*YW +: YW];
        gnx_s       = next_x[int'(grant_idx_s)*XW +: XW];
        gny_s       = next_y[int'(grant_idx_s)*YW +: YW];
        gtile_s     = sprite_tile[int'(grant_idx_s)*TILE_W +: TILE_W];
        range_ok_s  = ({1'b0, gcx_s} < COLS_L) && ({1'b0, gnx_s} < COLS_L) &&
                      ({1'b0, gcy_s} < ROWS_L) && ({1'b0, gny_s} < ROWS_L);
        same_cell_s = (gcx_s == gnx_s) && (gcy_s == gny_s);
    end

    // Tile left behind at the old cell, and tile found at the target cell.
    always_comb begin
        erase_tile_s = EATS_MASK[idx_r] ? EMPTY_T : under_r[idx_r];
        old_tile_s   = get_col(redata, nx_r);
    end

    // Writer FSM: grant, erase read-modify-write, draw read-modify-write,
    // completion pulse. Every output is a register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            cx_r       <= '0;
            cy_r       <= '0;
            nx_r       <= '0;
            ny_r       <= '0;
            tile_r     <= '0;
            rr_ptr_r   <= '0;
            wait_cnt_r <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                under_r[i] <= EMPTY_T;
            end
            wren     <= 1'b0;
            wraddr   <= '0;
            wrdata   <= '0;
            done     <= '0;
            err      <= 1'b0;
            hit_tile <= EMPTY_T;
            busy     <= 1'b0;
        end else begin
            wren <= 1'b0;
            done <= '0;
            err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        idx_r    <= grant_idx_s;
                        cx_r     <= gcx_s;
                        cy_r     <= gcy_s;
                        nx_r     <= gnx_s;
                        ny_r     <= gny_s;
                        tile_r   <= gtile_s;
                        rr_ptr_r <= next_ptr(grant_idx_s);
                        busy     <= 1'b1;
                        if (!range_ok_s) begin
                            state_r  <= ST_DONE;
                            done     <= onehot(grant_idx_s);
                            err      <= 1'b1;
                            hit_tile <= EMPTY_T;
                        end else if (same_cell_s) begin
                            state_r  <= ST_DONE;
                            done     <= onehot(grant_idx_s);
                            hit_tile <= under_r[grant_idx_s];
                        end else begin
                            state_r <= ST_RD_E;
                            wraddr  <= gcy_s;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RD_E: begin
                    wait_cnt_r <= '0;
                    state_r    <= ST_WAIT_E;
                end
                ST_WAIT_E: begin
                    if (wait_cnt_r == LAT_LAST) begin
                        wrdata  <= put_col(redata, cx_r, erase_tile_s);
                        wren    <= 1'b1;
                        state_r <= ST_WR_E;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                ST_WR_E: begin
                    // Address moves only after the write cycle is over.
                    wraddr  <= ny_r;
                    state_r <= ST_RD_D;
                end
                ST_RD_D: begin
                    wait_cnt_r <= '0;
                    state_r    <= ST_WAIT_D;
                end
                ST_WAIT_D: begin
                    if (wait_cnt_r == LAT_LAST) begin
                        hit_tile       <= old_tile_s;
                        under_r[idx_r] <= old_tile_s;
                        wrdata         <= put_col(redata, nx_r, tile_r);
                        wren           <= 1'b1;
                        state_r        <= ST_WR_D;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                ST_WR_D: begin
                    done    <= onehot(idx_r);
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_map_writer.sv
// Directed and randomized bench for sprite_map_writer: a latency-2 RAM model on
// port B and a tile-grid reference model applying the erase/draw rules.
module tb_sprite_map_writer;
    import pacman_map_pkg::*;

    localparam int N    = 3;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int TW   = 4;
    localparam int LAT  = 2;
    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);
    localparam int RW   = COLS * TW;
    localparam logic [N-1:0] EATS = 3'b001;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*XW-1:0]   curr_x, next_x;
    logic [N*YW-1:0]   curr_y, next_y;
    logic [N*TW-1:0]   sprite_tile;
    logic [RW-1:0]     redata;
    logic [YW-1:0]     wraddr;
    logic [RW-1:0]     wrdata;
    logic              wren;
    logic [N-1:0]      done;
    logic              err;
    logic [TW-1:0]     hit_tile;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    sprite_map_writer #(
        .NUM_SPRITES (N), .COLS (COLS), .ROWS (ROWS),
        .TILE_W (TW), .RD_LATENCY (LAT), .EATS_MASK (EATS)
    ) dut (
        .CLOCK_50 (clk), .reset (reset), .req (req),
        .curr_x (curr_x), .curr_y (curr_y), .next_x (next_x), .next_y (next_y),
        .sprite_tile (sprite_tile), .redata (redata),
        .wraddr (wraddr), .wrdata (wrdata), .wren (wren),
        .done (done), .err (err), .hit_tile (hit_tile), .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: two-stage read pipeline, write on wren, preload on request.
    logic [RW-1:0] mem [ROWS];
    logic [RW-1:0] preload [ROWS];
    logic          do_load = 1'b0;
    logic [RW-1:0] pipe1;
    logic [YW-1:0] prev_addr;
    int            cyc = 0;
    int            addr_viol = 0;
    int            wr_cyc_q[$];
    int            wr_addr_q[$];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        pipe1     <= mem[wraddr];
        redata    <= pipe1;
        prev_addr <= wraddr;
        if (do_load) begin
            for (int r = 0; r < ROWS; r++) mem[r] <= preload[r];
        end else if (wren) begin
            mem[wraddr] <= wrdata;
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(int'(wraddr));
            if (wraddr != prev_addr) addr_viol <= addr_viol + 1;
        end
    end

    // Reference model: plain tile grid and per-sprite covered tile.
    int model_map [ROWS][COLS];
    int model_under [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tile_at(input int r, input int c);
        logic [RW-1:0] row;
        row = mem[r];
        return int'(row[(COLS - 1 - c) * TW +: TW]);
    endfunction

    function automatic int map_diff();
        int d;
        d = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (tile_at(r, c) != model_map[r][c]) d++;
        return d;
    endfunction

    // Apply one full erase+draw to the model; returns the tile found at next.
    function automatic int model_move(input int i, input int cx, input int cy,
                                      input int nx, input int ny);
        int h;
        model_map[cy][cx] = EATS[i] ? TILE_EMPTY : model_under[i];
        h = model_map[ny][nx];
        model_under[i] = h;
        model_map[ny][nx] = (i == 0) ? TILE_PACMAN : TILE_GHOST;
        return h;
    endfunction

    task automatic set_slot(input int i, input int cx, input int cy, input int nx, input int ny);
        curr_x[i*XW +: XW] = XW'(cx);
        curr_y[i*YW +: YW] = YW'(cy);
        next_x[i*XW +: XW] = XW'(nx);
        next_y[i*YW +: YW] = YW'(ny);
        sprite_tile[i*TW +: TW] = TW'((i == 0) ? TILE_PACMAN : TILE_GHOST);
    endtask

    task automatic run_move(input int i, input int cx, input int cy, input int nx,
                            input int ny, input string tag);
        int exp_lat, exp_hit, exp_nwr, t, n0, lat, nwr;
        bit exp_err, seen;
        logic [N-1:0] exp_done, obs_done;
        logic obs_err;
        logic [TW-1:0] obs_hit;
        exp_err = (cx >= COLS) || (nx >= COLS) || (cy >= ROWS) || (ny >= ROWS);
        if (exp_err) begin
            exp_lat = 1; exp_nwr = 0; exp_hit = 0;
        end else if (cx == nx && cy == ny) begin
            exp_lat = 1; exp_nwr = 0; exp_hit = model_under[i];
        end else begin
            exp_lat = 5 + 2 * LAT; exp_nwr = 2;
            exp_hit = model_move(i, cx, cy, nx, ny);
        end
        exp_done = '0;
        exp_done[i] = 1'b1;
        @(negedge clk);
        set_slot(i, cx, cy, nx, ny);
        req = '0;
        req[i] = 1'b1;
        t = cyc; n0 = wr_cyc_q.size(); seen = 1'b0; lat = 0;
        obs_done = '0; obs_err = 1'b0; obs_hit = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = 1'b1; lat = cyc - t;
                obs_done = done; obs_err = err; obs_hit = hit_tile;
                req = '0;
            end
        end
        req = '0;
        nwr = wr_cyc_q.size() - n0;
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " done_vec"}, 64'(obs_done), 64'(exp_done));
        chk({tag, " err"}, 64'(obs_err), 64'(exp_err));
        if (!exp_err) chk({tag, " hit_tile"}, 64'(obs_hit), 64'(exp_hit));
        chk({tag, " write_count"}, 64'(nwr), 64'(exp_nwr));
        if (exp_nwr == 2 && nwr == 2) begin
            chk({tag, " erase_wr_cycle"}, 64'(wr_cyc_q[n0] - t), 64'(2 + LAT));
            chk({tag, " draw_wr_cycle"}, 64'(wr_cyc_q[n0+1] - t), 64'(4 + 2 * LAT));
            chk({tag, " erase_wr_row"}, 64'(wr_addr_q[n0]), 64'(cy));
            chk({tag, " draw_wr_row"}, 64'(wr_addr_q[n0+1]), 64'(ny));
        end
        chk({tag, " map"}, 64'(map_diff()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] row;
        int ord[4];
        int dcy[4];
        int nd, t, n0, obs_first;

        reset = 1'b1; req = '0;
        curr_x = '0; curr_y = '0; next_x = '0; next_y = '0; sprite_tile = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                model_map[r][c] = (r == 20) ? TILE_PILL : int'($urandom_range(0, 4));
            end
        end
        model_map[3][5] = TILE_PILL;
        model_map[4][5] = TILE_PILL;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) row[(COLS - 1 - c) * TW +: TW] = TW'(model_map[r][c]);
            preload[r] = row;
        end
        for (int i = 0; i < N; i++) model_under[i] = TILE_EMPTY;

        repeat (3) @(negedge clk);
        do_load = 1'b1;
        @(negedge clk);
        do_load = 1'b0;
        chk("rst wren", 64'(wren), 64'd0);
        chk("rst wraddr", 64'(wraddr), 64'd0);
        chk("rst wrdata", 64'(wrdata), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst hit_tile", 64'(hit_tile), 64'(TILE_EMPTY));
        chk("rst busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("preload map", 64'(map_diff()), 64'd0);

        // All three requesting continuously: 0,1,2,0 with 10-cycle spacing.
        set_slot(0, 0, 0, 1, 0);
        set_slot(1, 0, 1, 1, 1);
        set_slot(2, 0, 2, 1, 2);
        req = 3'b111;
        nd = 0;
        for (int k = 0; k < 100 && nd < 4; k++) begin
            @(negedge clk);
            if (done != '0) begin
                ord[nd] = (done == 3'b001) ? 0 : (done == 3'b010) ? 1 : (done == 3'b100) ? 2 : 9;
                dcy[nd] = cyc;
                nd++;
                if (nd == 4) req = '0;
            end
        end
        req = '0;
        void'(model_move(0, 0, 0, 1, 0));
        void'(model_move(1, 0, 1, 1, 1));
        void'(model_move(2, 0, 2, 1, 2));
        void'(model_move(0, 0, 0, 1, 0));
        chk("rr done_count", 64'(nd), 64'd4);
        if (nd == 4) begin
            chk("rr order0", 64'(ord[0]), 64'd0);
            chk("rr order1", 64'(ord[1]), 64'd1);
            chk("rr order2", 64'(ord[2]), 64'd2);
            chk("rr order3", 64'(ord[3]), 64'd0);
            for (int g = 1; g < 4; g++) chk("rr gap", 64'(dcy[g] - dcy[g-1]), 64'(6 + 2 * LAT));
        end
        chk("rr map", 64'(map_diff()), 64'd0);

        // Ghost on a pill row: park on a pill, then step and restore it.
        run_move(1, 9, 20, 10, 20, "ghost_park");
        run_move(1, 10, 20, 11, 20, "ghost_step");
        chk("ghost col10 pill", 64'(tile_at(20, 10)), 64'(TILE_PILL));
        chk("ghost col11 ghost", 64'(tile_at(20, 11)), 64'(TILE_GHOST));

        // Pacman eats: pill cell becomes empty and stays empty after leaving.
        run_move(0, 5, 3, 5, 4, "pac_eat");
        chk("pac old cell empty", 64'(tile_at(3, 5)), 64'(TILE_EMPTY));
        chk("pac new cell", 64'(tile_at(4, 5)), 64'(TILE_PACMAN));
        run_move(0, 5, 4, 6, 4, "pac_leave");
        chk("pac pill not restored", 64'(tile_at(4, 5)), 64'(TILE_EMPTY));

        run_move(2, 3, 3, 40, 3, "range_x40");
        run_move(1, 7, 7, 7, 7, "same_cell");

        for (int n = 0; n < 25; n++) begin
            int ri, rcx, rcy, rnx, rny;
            ri  = int'($urandom_range(0, N - 1));
            rcx = ($urandom_range(0, 11) == 0) ? int'($urandom_range(COLS, 63)) : int'($urandom_range(0, COLS - 1));
            rcy = ($urandom_range(0, 11) == 0) ? int'($urandom_range(ROWS, 31)) : int'($urandom_range(0, ROWS - 1));
            rnx = int'($urandom_range(0, COLS - 1));
            rny = ($urandom_range(0, 11) == 0) ? int'($urandom_range(ROWS, 31)) : int'($urandom_range(0, ROWS - 1));
            if ($urandom_range(0, 6) == 0) begin
                rnx = rcx; rny = rcy;
            end else if ($urandom_range(0, 3) == 0) begin
                rny = rcy;
            end
            run_move(ri, rcx, rcy, rnx, rny, $sformatf("rand%0d", n));
        end

        // Reset while the draw read is pending: erase lands, draw never does.
        @(negedge clk);
        set_slot(0, 12, 9, 12, 10);
        req = 3'b001;
        t = cyc; n0 = wr_cyc_q.size();
        for (int k = 0; k < 20 && cyc < t + 6; k++) @(negedge clk);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        chk("abort wren", 64'(wren), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort hit_tile", 64'(hit_tile), 64'(TILE_EMPTY));
        @(negedge clk);
        chk("abort wren2", 64'(wren), 64'd0);
        reset = 1'b0;
        chk("abort writes", 64'(wr_cyc_q.size() - n0), 64'd1);
        model_map[9][12] = TILE_EMPTY;
        for (int i = 0; i < N; i++) model_under[i] = TILE_EMPTY;
        chk("abort map", 64'(map_diff()), 64'd0);

        @(negedge clk);
        set_slot(0, 12, 9, 12, 10);
        set_slot(1, 20, 15, 21, 15);
        set_slot(2, 30, 25, 30, 26);
        req = 3'b111;
        obs_first = 0;
        for (int k = 0; k < 40 && obs_first == 0; k++) begin
            @(negedge clk);
            if (done != '0) begin
                obs_first = int'(done);
                req = '0;
            end
        end
        req = '0;
        chk("post reset first grant", 64'(obs_first), 64'd1);
        void'(model_move(0, 12, 9, 12, 10));
        repeat (2) @(negedge clk);
        chk("post reset map", 64'(map_diff()), 64'd0);
        chk("wren on addr change", 64'(addr_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
